// File: rtl/switch_debounce_irq_pkg.sv
// Shared constants and helpers for the switch conditioning block.
package switch_debounce_pkg;

  // Edge selection codes for the EDGE_MODE parameter.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_BOTH    = 2;

  // 1 ms of stable input at a 50 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // True when a debounced toggle to new_level counts as an edge event
  // under the given edge mode.
  function automatic logic edge_hit(input int mode, input logic new_level);
    if (mode == EDGE_RISING) begin
      return new_level;
    end else if (mode == EDGE_FALLING) begin
      return ~new_level;
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/switch_debounce_irq_if.sv
// Bus between the switch conditioning block and the HPS-side PIO/IRQ logic.
interface switch_debounce_irq_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] switches_raw;
  logic [WIDTH-1:0] switches_export;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] capture_clear;
  logic [WIDTH-1:0] edge_capture;
  logic             irq;

  // HPS / board side: supplies pads, mask and clear strobes.
  modport master (
    output switches_raw,
    output irq_mask,
    output capture_clear,
    input  switches_export,
    input  edge_capture,
    input  irq
  );

  // Conditioning block side.
  modport slave (
    input  switches_raw,
    input  irq_mask,
    input  capture_clear,
    output switches_export,
    output edge_capture,
    output irq
  );

endinterface

// File: rtl/switch_debounce_irq_debounce_bit.sv
// One switch bit: 2-FF synchroniser, debounce counter, stable level and
// a single-cycle edge pulse coinciding with the stable-level update.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int EDGE_MODE       = EDGE_BOTH
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic edge_pulse
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          differ;
  logic          expire;

  // Decide whether this cycle completes a debounce window.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    differ     = sync_q[1] ^ stable_q;
    expire     = differ && (cnt_q == CNT_MAX);
    edge_pulse = expire && edge_hit(EDGE_MODE, sync_q[1]);
  end

  // Synchronise the pad, count consecutive differing cycles, toggle on expiry.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (!differ) begin
        cnt_q <= '0;
      end else if (expire) begin
        stable_q <= ~stable_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/switch_debounce_irq.sv
// Top: per-bit debouncers, sticky edge capture register and level IRQ.
module switch_debounce_irq
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int EDGE_MODE       = EDGE_BOTH
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  switch_debounce_irq_if.slave bus
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] capture_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_MODE       (EDGE_MODE)
    ) u_bit (
      .clk        (clk_clk),
      .rst        (reset_reset),
      .raw        (bus.switches_raw[g]),
      .level      (level[g]),
      .edge_pulse (edge_pulse[g])
    );
  end

  // Sticky capture: a new edge wins over a simultaneous clear strobe.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      capture_q <= '0;
    end else begin
      capture_q <= (capture_q & ~bus.capture_clear) | edge_pulse;
    end
  end

  assign bus.switches_export = level;
  assign bus.edge_capture    = capture_q;
  assign bus.irq             = |(capture_q & bus.irq_mask);

endmodule
